dst_router: RTL and testbench

Write-back distributor for the 16-bit datapath, mirroring the source multiplexer on the other side of the bus. It accepts one result word with a 2-bit destination code through a valid/ready handshake and holds it in an output register. It then presents it to exactly one of four destinations (A–D) until that destination acknowledges. A per-transfer watchdog drops words that are never acknowledged and reports which destination stalled.

---
 rtl/dst_router_pkg.sv | 22 ++
 rtl/dst_router.sv | 74 +++++++
 tb/tb_dst_router.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dst_router_pkg.sv
// Shared definitions for the write-back distributor: destination codes,
// FSM state encoding and the code-to-strobe helper.
package dst_router_pkg;

  localparam logic [1:0] DST_A = 2'd0;
  localparam logic [1:0] DST_B = 2'd1;
  localparam logic [1:0] DST_C = 2'd2;
  localparam logic [1:0] DST_D = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rt_state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] code);
    logic [3:0] s;
    s = 4'b0000;
    s[code] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/dst_router.sv
// Holds one result word and strobes it into one of four destinations until
// acknowledged; a per-transfer watchdog drops words that are never taken.
module dst_router
  import dst_router_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       dst_selection,
  output logic [WIDTH-1:0] dst_data,
  output logic [3:0]       dst_we,
  input  logic [3:0]       dst_ack,
  output logic             err,
  output logic [1:0]       err_dst
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CMAX  = '1;

  rt_state_t     state, state_nxt;
  logic [1:0]    sel;
  logic [CW-1:0] cnt;
  logic          busy, ack_sel, done, drop, accept;

  assign busy    = (state == BUSY);
  assign ack_sel = dst_ack[sel];
  assign done    = busy & ack_sel;
  // An ACK on the would-be drop edge wins, so drop requires ACK low.
  assign drop    = (TIMEOUT > 0) && busy && !ack_sel && (cnt == TLAST);
  assign accept  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept)            state_nxt = BUSY;
    else if (done || drop) state_nxt = IDLE;
  end

  always_comb begin
    in_ready = !busy | done | drop;
    dst_we   = busy ? onehot4(sel) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dst_data <= '0;
      sel      <= DST_A;
      cnt      <= '0;
      err      <= 1'b0;
      err_dst  <= DST_A;
    end else begin
      err <= drop;
      if (drop) err_dst <= sel;
      if (accept) begin
        dst_data <= in_data;
        sel      <= dst_selection;
      end
      // With the watchdog disabled the counter just saturates.
      if (accept || done || drop)      cnt <= '0;
      else if (busy && !ack_sel && cnt != CMAX) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dst_router.sv
// Directed bench for dst_router: a default instance for data-path cases and a
// TIMEOUT=4 instance for the watchdog; both share the stimulus.
module tb_dst_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic [1:0]  dst_selection;
  logic [3:0]  dst_ack;

  logic        in_ready, err;
  logic [15:0] dst_data;
  logic [3:0]  dst_we;
  logic [1:0]  err_dst;

  logic        wd_ready, wd_err;
  logic [15:0] wd_data;
  logic [3:0]  wd_we;
  logic [1:0]  wd_err_dst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dst_router #(.WIDTH(16), .TIMEOUT(255)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .dst_selection(dst_selection), .dst_data(dst_data),
    .dst_we(dst_we), .dst_ack(dst_ack), .err(err), .err_dst(err_dst)
  );

  dst_router #(.WIDTH(16), .TIMEOUT(4)) u_wd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(wd_ready),
    .in_data(in_data), .dst_selection(dst_selection), .dst_data(wd_data),
    .dst_we(wd_we), .dst_ack(dst_ack), .err(wd_err), .err_dst(wd_err_dst)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] exp_we;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; dst_selection = '0; dst_ack = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_we",    {28'd0, dst_we},   32'd0);
    chk("rst_data",  {16'd0, dst_data}, 32'd0);
    chk("rst_err",   {31'd0, err},      32'd0);
    chk("rst_errdst",{30'd0, err_dst},  32'd0);

    // single write, ACK[2] already high
    in_valid = 1'b1; in_data = 16'hBEEF; dst_selection = 2'd2; dst_ack = 4'b0100;
    #1 chk("sw_ready0", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("sw_we",    {28'd0, dst_we},   32'h4);
    chk("sw_data",  {16'd0, dst_data}, 32'hBEEF);
    chk("sw_ready1",{31'd0, in_ready}, 32'd1);
    chk("sw_err",   {31'd0, err},      32'd0);
    tick();
    chk("sw_we_off",{28'd0, dst_we},   32'h0);
    chk("sw_hold",  {16'd0, dst_data}, 32'hBEEF);

    // streaming, all ACKs high
    dst_ack = 4'hF; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 16'(i + 1); dst_selection = 2'(i);
      #1;
      chk("st_ready", {31'd0, in_ready}, 32'd1);
      if (i > 0) begin
        exp_we = 4'b0001 << ((i - 1) % 4);
        chk("st_we",   {28'd0, dst_we},   {28'd0, exp_we});
        chk("st_data", {16'd0, dst_data}, 32'(i));
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("st_we_last",   {28'd0, dst_we},   32'h8);
    chk("st_data_last", {16'd0, dst_data}, 32'h8);
    tick();
    chk("st_idle", {28'd0, dst_we}, 32'h0);

    // backpressure on B with other ACKs toggling
    in_valid = 1'b1; in_data = 16'hA5A5; dst_selection = 2'd1; dst_ack = 4'b0000;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      dst_ack = (c % 2 == 0) ? 4'b1101 : 4'b0100;
      #1;
      chk("bp_we",    {28'd0, dst_we},   32'h2);
      chk("bp_data",  {16'd0, dst_data}, 32'hA5A5);
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    dst_ack = 4'b0010;
    #1;
    chk("bp_we_last", {28'd0, dst_we},   32'h2);
    chk("bp_ready_ack",{31'd0, in_ready}, 32'd1);
    tick();
    dst_ack = 4'b0000;
    chk("bp_idle", {28'd0, dst_we}, 32'h0);
    chk("bp_err",  {31'd0, err},    32'd0);

    // reset while busy
    in_valid = 1'b1; in_data = 16'h7777; dst_selection = 2'd0; dst_ack = 4'b0000;
    tick();
    in_valid = 1'b0;
    #1 chk("mr_busy", {28'd0, dst_we}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_we",    {28'd0, dst_we},   32'h0);
    chk("mr_ready", {31'd0, in_ready}, 32'd1);
    chk("mr_data",  {16'd0, dst_data}, 32'h0);
    chk("mr_err",   {31'd0, err},      32'd0);

    // accept on done: A then D without a gap
    in_valid = 1'b1; in_data = 16'h1234; dst_selection = 2'd0; dst_ack = 4'b0000;
    tick();
    in_data = 16'h5678; dst_selection = 2'd3; dst_ack = 4'b0001;
    #1;
    chk("ad_we0",    {28'd0, dst_we},   32'h1);
    chk("ad_data0",  {16'd0, dst_data}, 32'h1234);
    chk("ad_ready0", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; dst_ack = 4'b0000;
    #1;
    chk("ad_we1",    {28'd0, dst_we},   32'h8);
    chk("ad_data1",  {16'd0, dst_data}, 32'h5678);
    chk("ad_ready1", {31'd0, in_ready}, 32'd0);
    dst_ack = 4'b1000;
    tick();
    dst_ack = 4'b0000;
    chk("ad_idle", {28'd0, dst_we}, 32'h0);

    // watchdog drop, TIMEOUT=4, sel=D
    do_reset();
    in_valid = 1'b1; in_data = 16'hDEAD; dst_selection = 2'd3; dst_ack = 4'b0000;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk("wd_we",    {28'd0, wd_we},    32'h8);
      chk("wd_err0",  {31'd0, wd_err},   32'd0);
      chk("wd_ready", {31'd0, wd_ready}, (c == 4) ? 32'd1 : 32'd0);
      tick();
    end
    chk("wd_drop_we",  {28'd0, wd_we},      32'h0);
    chk("wd_drop_err", {31'd0, wd_err},     32'd1);
    chk("wd_drop_dst", {30'd0, wd_err_dst}, 32'd3);
    tick();
    chk("wd_err_pulse", {31'd0, wd_err},     32'd0);
    chk("wd_dst_hold",  {30'd0, wd_err_dst}, 32'd3);

    // ACK on the would-be drop cycle wins (sel=C)
    in_valid = 1'b1; in_data = 16'hCAFE; dst_selection = 2'd2; dst_ack = 4'b0000;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    dst_ack = 4'b0100;
    #1 chk("wd_save_we", {28'd0, wd_we}, 32'h4);
    tick();
    dst_ack = 4'b0000;
    chk("wd_save_idle", {28'd0, wd_we},      32'h0);
    chk("wd_save_err",  {31'd0, wd_err},     32'd0);
    tick();
    chk("wd_save_err2", {31'd0, wd_err},     32'd0);
    chk("wd_save_dst",  {30'd0, wd_err_dst}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
